spike_event_encoder: RTL and testbench
======================================

SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set event FIFO entries (power of two, 2..16).
REQ-002 Parameter WINDOW_LOG2, default 6, SHALL set rate window length 2^WINDOW_LOG2 cycles.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  capture enable
- spike_in  in  1  neuron spike, one event per high cycle
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  FIFO non-empty
- out_data  out  8  head inter-spike interval (ISI)
- fifo_full  out  1  occupancy == FIFO_DEPTH
- drop_count  out  8  events lost to full FIFO
- rate_out  out  WINDOW_LOG2+1  spikes counted in last completed window
- rate_valid  out  1  one-cycle pulse when rate_out updates

Function
REQ-004 Capture cycle: rising clk edge with en=1; with en=0, ISI counter, window counter and spike counter SHALL hold, and no push SHALL occur.
REQ-005 ISI counter (8 bit) SHALL increment by 1 on capture cycles with spike_in=0, saturating at 255.
REQ-006 On a capture cycle with spike_in=1, push value SHALL be the current ISI count, and the ISI counter SHALL load 0.
- Adjacent-cycle spikes push 0; ISI = number of non-spike capture cycles between spikes.
REQ-007 FIFO SHALL be first-word-fall-through: out_valid = (occupancy != 0), out_data = head entry, both driven from registers only.
REQ-008 Pop SHALL occur on a rising edge with out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL have no effect.
REQ-009 Latency: spike captured at edge N into empty FIFO SHALL give out_valid=1 with that value after edge N.
REQ-010 Push when full without same-cycle pop SHALL be discarded, FIFO unchanged, drop_count +1 saturating at 255; ISI counter still loads 0.
REQ-011 Simultaneous push and pop when full SHALL both succeed: occupancy stays FIFO_DEPTH, no drop.
REQ-012 Simultaneous push and pop when empty: pushed value SHALL be written; occupancy 0->1 (no pop of empty).
REQ-013 Read/write pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly FIFO.
REQ-014 Window counter (WINDOW_LOG2 bits) SHALL increment on every capture cycle, wrapping 2^WINDOW_LOG2-1 -> 0.
REQ-015 Spike counter SHALL increment on capture cycles with spike_in=1, irrespective of FIFO full.
REQ-016 On the capture cycle where window counter wraps, rate_out SHALL load spike counter plus that cycle's spike_in, spike counter SHALL clear to 0, rate_valid SHALL be 1 for exactly the following cycle.
REQ-017 Max rate_out = 2^WINDOW_LOG2 (all-spike window), so no overflow.
REQ-018 fifo_full SHALL be registered-state derived, asserted iff occupancy == FIFO_DEPTH.

Reset
REQ-019 reset=1 SHALL asynchronously clear: ISI counter, window counter, spike counter, pointers, occupancy, drop_count, rate_out to 0; out_valid, rate_valid, fifo_full to 0.
REQ-020 FIFO storage contents need not reset; out_data is don't-care while out_valid=0.
REQ-021 Reset asserted mid-operation SHALL discard all queued events and partial window; first capture after release starts ISI and window from 0.

Verification
REQ-022 en=1, out_ready=1, spikes at captures 3 and 8 after reset -> out_data 3 then 4, each out_valid one cycle after its spike edge.
REQ-023 out_ready=0, spikes every cycle for 6 captures (DEPTH 4) -> pushes 0,0,0,0 stored, fifo_full=1, drop_count=2; then out_ready=1 drains four 0s, out_valid falls.
REQ-024 FIFO full, out_ready=1 and spike same edge -> occupancy stays 4, drop_count unchanged, new value at tail.
REQ-025 WINDOW_LOG2=6, 10 spikes in first 64 captures incl. one on capture 64 -> rate_out=10, rate_valid single pulse; en=0 for 20 cycles mid-window delays pulse by 20.
REQ-026 No spike for 300 captures then spike -> out_data=255; reset asserted with 3 queued -> out_valid=0 immediately, drop_count=0.

Source files
------------

// File: rtl/spike_event_encoder.sv
// Spike event encoder: queues inter-spike intervals in a first-word-fall-through FIFO
// and reports the spike count of each completed rate window.
module spike_event_encoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WINDOW_LOG2 = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   spike_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   fifo_full,
    output logic [7:0]             drop_count,
    output logic [WINDOW_LOG2:0]   rate_out,
    output logic                   rate_valid
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int RW = WINDOW_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             isi_q, isi_d;
    logic [7:0]             drop_q, drop_d;
    logic [WINDOW_LOG2-1:0] win_q, win_d;
    logic [RW-1:0]          spk_q, spk_d, rate_q, rate_d;
    logic                   valid_q, full_q, rv_q;
    logic                   push_req_s, pop_s, push_s, drop_s, wrap_s;

    // Handshake decode; a full FIFO still accepts a push when the head leaves this edge.
    always_comb begin
        push_req_s = en & spike_in;
        pop_s      = valid_q & out_ready;
        push_s     = push_req_s & (~full_q | pop_s);
        drop_s     = push_req_s & full_q & ~pop_s;
        wrap_s     = en & (&win_q);
    end

    // Next-state for pointers, occupancy, ISI, drops and the rate window.
    always_comb begin
        wr_d   = push_s ? wr_q + PW'(1) : wr_q;
        rd_d   = pop_s  ? rd_q + PW'(1) : rd_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (!en) begin
            isi_d = isi_q;
        end else if (spike_in) begin
            isi_d = 8'd0;
        end else begin
            isi_d = (isi_q != 8'd255) ? isi_q + 8'd1 : isi_q;
        end
        drop_d = (drop_s && drop_q != 8'd255) ? drop_q + 8'd1 : drop_q;
        win_d  = en ? win_q + WINDOW_LOG2'(1) : win_q;
        if (wrap_s) begin
            spk_d  = '0;
            rate_d = spk_q + RW'(spike_in);
        end else begin
            spk_d  = en ? spk_q + RW'(spike_in) : spk_q;
            rate_d = rate_q;
        end
    end

    // Control and status registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            isi_q   <= 8'd0;
            drop_q  <= 8'd0;
            win_q   <= '0;
            spk_q   <= '0;
            rate_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            isi_q   <= isi_d;
            drop_q  <= drop_d;
            win_q   <= win_d;
            spk_q   <= spk_d;
            rate_q  <= rate_d;
            valid_q <= (cnt_d != '0);
            full_q  <= (cnt_d == DEPTH_C);
            rv_q    <= wrap_s;
        end
    end

    // Event storage is left unreset; its contents only matter while occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q] <= isi_q;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = mem_q[rd_q];
    assign fifo_full  = full_q;
    assign drop_count = drop_q;
    assign rate_out   = rate_q;
    assign rate_valid = rv_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed self-checking bench for spike_event_encoder (FIFO_DEPTH=4, WINDOW_LOG2=6).
module tb_spike_event_encoder;

    logic       clk, reset, en, spike_in, out_ready;
    logic       out_valid, fifo_full, rate_valid;
    logic [7:0] out_data, drop_count;
    logic [6:0] rate_out;
    int checks = 0;
    int errors = 0;

    spike_event_encoder #(.FIFO_DEPTH(4), .WINDOW_LOG2(6)) dut (
        .clk(clk), .reset(reset), .en(en), .spike_in(spike_in), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .fifo_full(fifo_full),
        .drop_count(drop_count), .rate_out(rate_out), .rate_valid(rate_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", fifo_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        checks++; if (rate_out !== 7'd0) begin errors++; $display("FAIL reset_rate got %0d want 0", rate_out); end
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %0b want 0", rate_valid); end
    endtask

    task automatic test_isi();
        logic exp_v;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int cap = 0; cap <= 8; cap++) begin
            spike_in = (cap == 3 || cap == 8);
            tick();
            exp_v = (cap == 3 || cap == 8);
            checks++;
            if (out_valid !== exp_v) begin errors++; $display("FAIL isi_valid cap %0d got %0b want %0b", cap, out_valid, exp_v); end
            if (cap == 3) begin
                checks++; if (out_data !== 8'd3) begin errors++; $display("FAIL isi_first got %0d want 3", out_data); end
            end
            if (cap == 8) begin
                checks++; if (out_data !== 8'd4) begin errors++; $display("FAIL isi_second got %0d want 4", out_data); end
            end
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        en = 1'b1; out_ready = 1'b0; spike_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL drop_full got %0b want 1", fifo_full); end
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL drop_count got %0d want 2", drop_count); end
        spike_in = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd0) begin
                errors++; $display("FAIL drain_%0d got valid %0b data %0d want valid 1 data 0", i, out_valid, out_data);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b want 0", out_valid); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL drain_full got %0b want 0", fifo_full); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [4];
        logic       pat [14];
        // Spike pattern producing pushes 0,1,2,3, then two idles and a spike (value 2).
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd2};
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            spike_in = pat[i];
            tick();
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pp_prefull got %0b want 1", fifo_full); end
        spike_in = pat[12]; out_ready = 1'b1;
        tick();
        spike_in = pat[13];
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pp_full got %0b want 1", fifo_full); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL pp_drop got %0d want 0", drop_count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                errors++; $display("FAIL pp_order_%0d got valid %0b data %0d want %0d", i, out_valid, out_data, exp_q[i]);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %0b want 0", out_valid); end
    endtask

    task automatic test_rate();
        int pulses = 0;
        int pulse_c = -1;
        int cap = 0;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        // First window: spikes on captures 5,10,...,45 and 64 -> 10.
        for (int c = 1; c <= 64; c++) begin
            spike_in = ((c % 5 == 0) && c <= 45) || (c == 64);
            tick();
            if (rate_valid) begin pulses++; pulse_c = c; end
        end
        checks++; if (pulses != 1 || pulse_c != 64) begin errors++; $display("FAIL rate_pulse1 got %0d pulses at %0d want 1 at 64", pulses, pulse_c); end
        checks++; if (rate_out !== 7'd10) begin errors++; $display("FAIL rate_out1 got %0d want 10", rate_out); end
        // Second window with a 20-cycle en=0 gap; spikes while disabled must be ignored.
        pulses = 0; pulse_c = -1;
        for (int c = 1; c <= 90; c++) begin
            en = !(c > 30 && c <= 50);
            if (en) begin
                cap++;
                spike_in = (cap == 1 || cap == 2 || cap == 64);
            end else begin
                spike_in = 1'b1;
            end
            tick();
            if (rate_valid) begin pulses++; pulse_c = c; end
            if (c == 65) begin
                checks++; if (rate_out !== 7'd10) begin errors++; $display("FAIL rate_hold got %0d want 10", rate_out); end
            end
        end
        checks++; if (pulses != 1 || pulse_c != 84) begin errors++; $display("FAIL rate_pulse2 got %0d pulses at %0d want 1 at 84", pulses, pulse_c); end
        checks++; if (rate_out !== 7'd3) begin errors++; $display("FAIL rate_out2 got %0d want 3", rate_out); end
    endtask

    task automatic test_sat_and_reset();
        do_reset();
        en = 1'b1; out_ready = 1'b0; spike_in = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        spike_in = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd255) begin errors++; $display("FAIL sat_isi got valid %0b data %0d want 255", out_valid, out_data); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL sat_drop got %0d want 1", drop_count); end
        spike_in = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0b want 0", out_valid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL async_drop got %0d want 0", drop_count); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL async_full got %0b want 0", fifo_full); end
        reset = 1'b0;
        en = 1'b1; spike_in = 1'b0;
        tick();
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin errors++; $display("FAIL post_reset got valid %0b data %0d want 1", out_valid, out_data); end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; spike_in = 1'b0; out_ready = 1'b0;
        test_reset();
        test_isi();
        test_full_drop();
        test_full_push_pop();
        test_rate();
        test_sat_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
